// File: rtl/add_arbiter_pkg.sv
// Types and helpers shared by add_arbiter, rr_arb2 and adder16.
package add_arbiter_pkg;
`include "add_arb_defs.vh"

    localparam int ADD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_EXEC = ST_EXEC,
        S_DONE = ST_DONE
    } arb_state_t;

    function automatic logic [1:0] id_onehot(input logic id);
        return (id == REQ1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/add_arb_defs.vh
// Shared encodings for the add_arbiter slice: FSM state codes and requester indices.
`ifndef ADD_ARB_DEFS_VH
`define ADD_ARB_DEFS_VH

localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_EXEC = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;

localparam logic REQ0 = 1'b0;
localparam logic REQ1 = 1'b1;

`endif

// File: rtl/add_arbiter_adder16.sv
// Adder16: plain 16-bit ripple-carry adder shared by both requesters.
module adder16
    import add_arbiter_pkg::*;
(
    input  logic [ADD_W-1:0] i_a,
    input  logic [ADD_W-1:0] i_b,
    input  logic             i_cin,
    output logic [ADD_W-1:0] o_s,
    output logic             o_cout
);

    logic [ADD_W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < ADD_W; i++) begin : g_fa
        assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[ADD_W];

endmodule

// File: rtl/add_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick with a "last winner" pointer.
module rr_arb2
    import add_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_valid,
    output logic o_winner
);

    logic r_last;

    // Pointer only moves on a contested grant; reset value lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= REQ1;
        end else if (i_take && i_req0 && i_req1) begin
            r_last <= o_winner;
        end
    end

    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = REQ0;
        if (i_req0 && i_req1) begin
            o_winner = ~r_last;
        end else if (i_req1) begin
            o_winner = REQ1;
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: shares one adder16 between two requesters, one 3-cycle op at a time.
// Optional grant counters gcnt0/gcnt1 are built when ADD_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting; winner of any request latched into gnt/res_id
// EXEC  | granted operands through the adder, sum/ovfl captured at end of cycle
// DONE  | one-cycle done pulse for res_id; requests ignored
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             res_id,
    output logic             busy
`ifdef ADD_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1
`endif
);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_ovfl;
    logic             r_res_id;

    logic             w_arb_valid;
    logic             w_arb_winner;
    logic             w_take;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    assign w_take = (r_state == S_IDLE) && w_arb_valid;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_req0   (req0),
        .i_req1   (req1),
        .i_take   (w_take),
        .o_valid  (w_arb_valid),
        .o_winner (w_arb_winner)
    );

    assign w_op_a = (r_res_id == REQ1) ? a1 : a0;
    assign w_op_b = (r_res_id == REQ1) ? b1 : b0;

    adder16 u_add (
        .i_a    (w_op_a),
        .i_b    (w_op_b),
        .i_cin  (1'b0),
        .o_s    (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Reset wins over everything, so an in-flight op is dropped without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_sum    <= '0;
            r_ovfl   <= 1'b0;
            r_res_id <= REQ0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    if (w_take) begin
                        r_gnt    <= id_onehot(w_arb_winner);
                        r_res_id <= w_arb_winner;
                    end
                end
                S_EXEC: begin
                    r_sum  <= w_sum;
                    r_ovfl <= w_cout;
                    r_done <= id_onehot(r_res_id);
                end
                S_DONE: begin
                    r_done <= '0;
                    r_gnt  <= '0;
                end
                default: begin
                    r_done <= '0;
                    r_gnt  <= '0;
                end
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = r_done;
    assign sum    = r_sum;
    assign ovfl   = r_ovfl;
    assign res_id = r_res_id;
    assign busy   = (r_state != S_IDLE);

`ifdef ADD_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_gcnt0;
    logic [CNT_W-1:0] r_gcnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gcnt0 <= '0;
            r_gcnt1 <= '0;
        end else if (w_take) begin
            if (w_arb_winner == REQ0) begin
                if (r_gcnt0 != CNT_MAX) r_gcnt0 <= r_gcnt0 + CNT_W'(1);
            end else begin
                if (r_gcnt1 != CNT_MAX) r_gcnt1 <= r_gcnt1 + CNT_W'(1);
            end
        end
    end

    assign gcnt0 = r_gcnt0;
    assign gcnt1 = r_gcnt1;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: single-request vector table plus tie, reset and drop sequences.
module tb_add_arbiter;

`ifdef ADD_ARB_STATS_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  gnt, done;
    logic [15:0] sum;
    logic        ovfl, res_id, busy;
`ifdef ADD_ARB_STATS_EN
    logic [TB_CNT_W-1:0] gcnt0, gcnt1;
    int exp_g0, exp_g1;
`endif

    int n_pass;
    int n_total;

    add_arbiter #(.WIDTH(16), .CNT_W(TB_CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .a1     (a1),
        .b1     (b1),
        .gnt    (gnt),
        .done   (done),
        .sum    (sum),
        .ovfl   (ovfl),
        .res_id (res_id),
        .busy   (busy)
`ifdef ADD_ARB_STATS_EN
        ,
        .gcnt0  (gcnt0),
        .gcnt1  (gcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic        id;
        logic [15:0] s;
        logic        ov;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic note_grant(input logic id);
`ifdef ADD_ARB_STATS_EN
        int lim;
        lim = (1 << TB_CNT_W) - 1;
        if (id == 1'b0) begin
            if (exp_g0 < lim) exp_g0++;
        end else begin
            if (exp_g1 < lim) exp_g1++;
        end
`else
        if (id !== 1'b0 && id !== 1'b1) $display("note: unknown grant id");
`endif
    endtask

    task automatic check_stats(input string name);
`ifdef ADD_ARB_STATS_EN
        check({name, "_gcnt0"}, 32'(gcnt0), 32'(exp_g0));
        check({name, "_gcnt1"}, 32'(gcnt1), 32'(exp_g1));
`else
        if (name.len() == 0) $display("note: empty stats tag");
`endif
    endtask

    initial begin
        logic [1:0] exp_oh;
        n_pass  = 0;
        n_total = 0;
`ifdef ADD_ARB_STATS_EN
        exp_g0 = 0;
        exp_g1 = 0;
`endif
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        //            r0    r1    a0        b0        a1        b1        id    sum       ovfl
        vecs[0] = '{1'b1, 1'b0, 16'h0003, 16'h0004, 16'h5555, 16'h1111, 1'b0, 16'h0007, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h2222, 16'h3333, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 16'hFFFE, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 16'hAAAA, 16'h0000, 16'h1234, 16'h4321, 1'b1, 16'h5555, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h7FFF, 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};

        step();
        step();
        check("rst_gnt",    32'(gnt),    32'h0);
        check("rst_done",   32'(done),   32'h0);
        check("rst_sum",    32'(sum),    32'h0);
        check("rst_ovfl",   32'(ovfl),   32'h0);
        check("rst_res_id", 32'(res_id), 32'h0);
        check("rst_busy",   32'(busy),   32'h0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'h0);
        check_stats("rst");

        for (int i = 0; i < 5; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            a0 = vecs[i].a0; b0 = vecs[i].b0; a1 = vecs[i].a1; b1 = vecs[i].b1;
            exp_oh = vecs[i].id ? 2'b10 : 2'b01;
            step();
            note_grant(vecs[i].id);
            check($sformatf("v%0d_gnt", i),  32'(gnt),  32'(exp_oh));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            check($sformatf("v%0d_nodone", i), 32'(done), 32'h0);
            step();
            check($sformatf("v%0d_done", i),   32'(done),   32'(exp_oh));
            check($sformatf("v%0d_sum", i),    32'(sum),    32'(vecs[i].s));
            check($sformatf("v%0d_ovfl", i),   32'(ovfl),   32'(vecs[i].ov));
            check($sformatf("v%0d_res_id", i), 32'(res_id), 32'(vecs[i].id));
            req0 = 1'b0; req1 = 1'b0;
            step();
            check($sformatf("v%0d_done_off", i), 32'(done), 32'h0);
            check($sformatf("v%0d_idle", i),     32'(busy), 32'h0);
        end

        // Continuous tie: grants alternate 0,1,0,1 with one done every 3 cycles.
        a0 = 16'h0100; b0 = 16'h0023; a1 = 16'h1000; b1 = 16'h2000;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            step();
            note_grant(k % 2 == 1);
            check($sformatf("tie%0d_gnt", k), 32'(gnt), 32'(exp_oh));
            step();
            check($sformatf("tie%0d_done", k), 32'(done), 32'(exp_oh));
            check($sformatf("tie%0d_sum", k),  32'(sum), (k % 2 == 0) ? 32'h0123 : 32'h3000);
            step();
            check($sformatf("tie%0d_gap", k), 32'(done), 32'h0);
        end
        check_stats("tie");

        // Tie goes to 0 (pointer now 1 -> 0), then reset lands while in EXEC.
        step();
        check("prerst_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        step();
`ifdef ADD_ARB_STATS_EN
        exp_g0 = 0;
        exp_g1 = 0;
`endif
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_gnt",  32'(gnt),  32'h0);
        check("midrst_sum",  32'(sum),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check_stats("midrst");
        rst = 1'b0;
        step();
        note_grant(1'b0);
        check("postrst_tie_gnt", 32'(gnt), 32'h1);
        step();
        check("postrst_done", 32'(done), 32'h1);
        check("postrst_sum",  32'(sum),  32'h0123);
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Granted request withdrawn during EXEC still completes.
        a0 = 16'h8000; b0 = 16'h8000;
        req0 = 1'b1;
        step();
        note_grant(1'b0);
        check("drop_gnt", 32'(gnt), 32'h1);
        req0 = 1'b0;
        step();
        check("drop_done", 32'(done), 32'h1);
        check("drop_sum",  32'(sum),  32'h0000);
        check("drop_ovfl", 32'(ovfl), 32'h1);
        step();
        check("drop_done_off", 32'(done), 32'h0);
        step();
        check("drop_stays_idle", 32'(busy), 32'h0);
        check_stats("end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one 16-bit ripple adder datapath (the team's Adder16 block) between two requesters.
- Round-robin arbitration, per-requester req/done handshake, registered sum and carry out.
- Sits between two client engines, e.g. address generator and accumulator, which would otherwise each need a private adder.
- One operation in flight at a time; 3-cycle occupancy per operation.

Parameters:
- WIDTH, 16, operand/sum width; fixed at 16 to match the adder datapath; any other value is unsupported.
- CNT_W, 16, width of the optional grant counters (only used with ADD_ARB_STATS_EN).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held high with stable a0/b0 until done0.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt  output  2  one-hot grant, registered; high during EXEC and DONE for the owner.
- done  output  2  one-hot completion pulse, one cycle, in DONE.
- sum  output  WIDTH  registered result, valid when done != 0.
- ovfl  output  1  registered unsigned carry out of bit 15, valid with sum.
- res_id  output  1  index of requester owning sum, valid with done.
- busy  output  1  high in EXEC and DONE.
- gcnt0, gcnt1  output  CNT_W each  grant counters (ADD_ARB_STATS_EN only).

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; gnt=0, done=0, sum=0, ovfl=0, res_id=0, busy=0; last pointer = 1, so requester 0 wins the first tie; counters = 0.
- Reset mid-operation: the in-flight operation is discarded and no done is issued.
- FSM states: IDLE, EXEC, DONE.
- IDLE, at least one req high at edge N: register the winner in gnt/res_id and go to EXEC.
  - Single request: that requester wins.
  - Both requests: winner = requester != last; last <= winner.
  - No request: stay in IDLE.
- EXEC (cycle N+1): operand mux selects a/b of the granted requester and feeds the adder. At the end of the cycle sum <= s, ovfl <= carry out; go to DONE.
- DONE (cycle N+2): done[res_id]=1 for exactly one cycle with sum/ovfl/res_id stable; go to IDLE. req inputs are ignored in DONE.
- Latency is 2 cycles from the req-sampling edge to the done pulse. Minimum request-to-request spacing is 3 cycles per grant. Under continuous dual requests, grants strictly alternate 0,1,0,1.
- The requester must deassert req in the cycle it sees done. If it is still high at the next IDLE edge, it is treated as a new request.
- If the granted req drops during EXEC, the operation still completes and done still pulses.
- Arithmetic: sum = (a+b) mod 2^16. ovfl = bit 16 of the unsigned sum; no signed-overflow flag.
- sum/ovfl hold their last value outside DONE and are meaningful only with done.

Optional Feature:
- Macro: ADD_ARB_STATS_EN.
- Defined: gcnt0/gcnt1 ports exist. The counter of the requester granted increments on each IDLE->EXEC transition and saturates at 2^CNT_W-1. Counters clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared header add_arb_defs.vh, include-guarded:
  - State encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_DONE=2'd2.
  - Requester index constants REQ0=1'b0, REQ1=1'b1.
- Sub-module rr_arb2: round-robin pointer plus winner/valid combinational output from req0, req1 and last. add_arbiter instantiates rr_arb2 and one Adder16; FSM, operand mux and output registers stay in add_arbiter.

Test Plan:
- Reset then req0=1, a0=16'h0003, b0=16'h0004 -> gnt=2'b01 one edge later, done=2'b01 two edges after sampling; sum=16'h0007, ovfl=0, res_id=0.
- req1 only, a1=16'hFFFF, b1=16'h0001 -> done=2'b10, sum=16'h0000, ovfl=1, res_id=1.
- req0 and req1 high simultaneously, held re-asserted -> grant order 0,1,0,1 over four operations, each done 3 cycles apart; sums match the respective operands.
- rst asserted during EXEC -> no done pulse; all outputs 0 next cycle; next tie is granted to requester 0.
- req0 dropped during EXEC (a0=16'h8000, b0=16'h8000) -> done0 still pulses with sum=16'h0000, ovfl=1.
- ADD_ARB_STATS_EN defined, 5 grants to req0 and 3 to req1 -> gcnt0=5, gcnt1=3; with CNT_W=2, 5 grants -> gcnt0 saturates at 3.
